// File: rtl/paint_pkg.sv
// paint_pkg: shared canvas constants, brush FSM state type and cursor step helper.
// Optional macro BRUSH_WRAP_EN: a step past an edge wraps to the opposite edge instead of saturating.
package paint_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;
  typedef enum logic [1:0] {IDLE, ARM, DRAW, RELEASE} brush_state_t;
  // one-pixel step of p in direction s within 0..lim, 9-bit so no 8-bit wrap
  function automatic logic [8:0] step_pos(input logic [8:0] p, input logic signed [1:0] s, input logic [8:0] lim);
`ifdef BRUSH_WRAP_EN
    return s[1] ? (p == '0 ? lim : p - 9'd1) : s[0] ? (p >= lim ? 9'd0 : p + 9'd1) : p;
`else
    return s[1] ? (p == '0 ? p : p - 9'd1) : s[0] ? (p >= lim ? p : p + 9'd1) : p;
`endif
  endfunction
endpackage

// File: rtl/brush_ctrl_if.sv
// brush_ctrl_if: handshake between brush_ctrl and the square-drawing stage / VGA adapter.
// master (brush_ctrl): drives X, Y, S_X, S_Y, start, plot, colour; reads sq_done.
// slave (square stage): the opposite directions.
interface brush_ctrl_if;
  import paint_pkg::*;
  logic [7:0] X;
  logic [7:0] Y;
  logic [3:0] S_X;
  logic [3:0] S_Y;
  logic start;
  logic plot;
  logic [COLOUR_W-1:0] colour;
  logic sq_done;
  modport master(output X, Y, S_X, S_Y, start, plot, colour, input sq_done);
  modport slave(input X, Y, S_X, S_Y, start, plot, colour, output sq_done);
endinterface

// File: rtl/brush_ctrl_move_rate.sv
// move_rate: turns one axis's neg/pos button pair plus the rate tick into a signed step.
// neg_i/pos_i: direction buttons; tick_i: step permitted this cycle; step_o: -1, 0 or +1.
module move_rate (
  input  logic              neg_i,
  input  logic              pos_i,
  input  logic              tick_i,
  output logic signed [1:0] step_o
);
  // opposing buttons cancel
  assign step_o = (!tick_i || neg_i == pos_i) ? 2'sd0 : neg_i ? -2'sd1 : 2'sd1;
endmodule

// File: rtl/brush_ctrl.sv
// brush_ctrl: cursor owner and paint-request sequencer in front of the square-drawing stage.
// clk/reset: clock, async active-high reset; btn_*: direction levels; paint: rising edge requests a draw;
// size_x/size_y/colour_in: request parameters; busy: not IDLE; sq: master side of brush_ctrl_if.
// Optional macro BRUSH_WRAP_EN (via paint_pkg::step_pos): edge steps wrap instead of saturating.
module brush_ctrl
  import paint_pkg::*;
#(
  parameter int MOVE_DIV = 2500000,
  parameter int INIT_X   = 80,
  parameter int INIT_Y   = 60
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                paint,
  input  logic [3:0]          size_x,
  input  logic [3:0]          size_y,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic                busy,
  brush_ctrl_if.master        sq
);
  localparam int CW = $clog2(MOVE_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(MOVE_DIV - 1);
  brush_state_t state_q, state_d;
  logic [7:0] x_q, x_d, y_q, y_d;
  logic [3:0] sx_q, sx_d, sy_q, sy_d;
  logic [COLOUR_W-1:0] col_q, col_d;
  logic start_q, start_d, paint_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic idle, held, tick, paint_edge;
  logic signed [1:0] step_x, step_y;
  logic [8:0] x_mv, y_mv, x_lim, y_lim;

  assign idle       = state_q == IDLE;
  assign held       = idle & (btn_left | btn_right | btn_up | btn_down);
  // a fresh press finds the counter at 0, so the first cycle steps immediately
  assign tick       = held & (cnt_q == '0);
  assign cnt_d      = !held ? '0 : cnt_q == CNT_MAX ? '0 : cnt_q + 1'b1;
  assign paint_edge = idle & paint & ~paint_q;

  move_rate u_rate_x (.neg_i(btn_left), .pos_i(btn_right), .tick_i(tick), .step_o(step_x));
  move_rate u_rate_y (.neg_i(btn_up),   .pos_i(btn_down),  .tick_i(tick), .step_o(step_y));

  // move within the current brush's limit, then clamp to the limit of the size being latched
  assign x_mv  = step_pos({1'b0, x_q}, step_x, 9'(SCREEN_W - 1) - {5'd0, sx_q});
  assign y_mv  = step_pos({1'b0, y_q}, step_y, 9'(SCREEN_H - 1) - {5'd0, sy_q});
  assign x_lim = 9'(SCREEN_W - 1) - {5'd0, size_x};
  assign y_lim = 9'(SCREEN_H - 1) - {5'd0, size_y};
  assign x_d   = !idle ? x_q : (paint_edge && x_mv > x_lim) ? x_lim[7:0] : x_mv[7:0];
  assign y_d   = !idle ? y_q : (paint_edge && y_mv > y_lim) ? y_lim[7:0] : y_mv[7:0];
  assign sx_d  = paint_edge ? size_x : sx_q;
  assign sy_d  = paint_edge ? size_y : sy_q;
  assign col_d = paint_edge ? colour_in : col_q;

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    case (state_q)
      IDLE: state_d = paint_edge ? ARM : IDLE;
      ARM: begin
        state_d = DRAW;
        start_d = 1'b1;
      end
      DRAW: begin
        state_d = sq.sq_done ? RELEASE : DRAW;
        start_d = ~sq.sq_done;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= 8'(INIT_X);
      y_q     <= 8'(INIT_Y);
      sx_q    <= '0;
      sy_q    <= '0;
      col_q   <= '0;
      start_q <= 1'b0;
      paint_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      col_q   <= col_d;
      start_q <= start_d;
      paint_q <= paint;
      cnt_q   <= cnt_d;
    end
  end

  assign sq.X      = x_q;
  assign sq.Y      = y_q;
  assign sq.S_X    = sx_q;
  assign sq.S_Y    = sy_q;
  assign sq.colour = col_q;
  assign sq.start  = start_q;
  assign sq.plot   = start_q & ~sq.sq_done;
  assign busy      = !idle;
endmodule
